// File: rtl/cpu_reg_dump_tx_if.sv
// cpu_reg_dump_tx_if
// Bundles the register snapshot inputs, the dump trigger and the
// status/serial outputs of cpu_reg_dump_tx.
//   master : drives trigger and reg_* ; observes busy, done, uart_tx
//   slave  : the dump transmitter itself
interface cpu_reg_dump_tx_if;
    logic        trigger;
    logic [7:0]  reg_a;
    logic [7:0]  reg_x;
    logic [7:0]  reg_y;
    logic [7:0]  reg_sp;
    logic [7:0]  reg_p;
    logic [15:0] reg_pc;
    logic        busy;
    logic        done;
    logic        uart_tx;

    modport master (
        output trigger, reg_a, reg_x, reg_y, reg_sp, reg_p, reg_pc,
        input  busy, done, uart_tx
    );

    modport slave (
        input  trigger, reg_a, reg_x, reg_y, reg_sp, reg_p, reg_pc,
        output busy, done, uart_tx
    );
endinterface

// File: rtl/cpu_reg_dump_tx.sv
// cpu_reg_dump_tx
// Snapshots the CPU debug registers on a trigger and sends them as one ASCII
// hex line "Ahh Xhh Yhh Shh Phhhh Fhh" + CR LF over a UART 8N1 transmitter.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   dbg     - cpu_reg_dump_tx_if.slave: trigger, reg_a/x/y/sp/p, reg_pc in;
//             busy, done (1-cycle pulse), uart_tx (idles high) out
// Build option: REG_DUMP_FLAGS_DECODE_EN prints the F field as eight flag
// letters (NVUBDIZC, '-' for clear) instead of two hex digits.
//
// state | meaning
// IDLE  | line idle, waiting for an accepted trigger
// START | start bit of the current character
// DATA  | 8 data bits, LSB first
// STOP  | stop bit; then next character or back to IDLE
module cpu_reg_dump_tx #(
    parameter int CLK_HZ = 27000000,
    parameter int BAUD   = 115200
) (
    input logic             clk,
    input logic             rst_n,
    cpu_reg_dump_tx_if.slave dbg
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
`ifdef REG_DUMP_FLAGS_DECODE_EN
    localparam logic [5:0] CHAR_LAST = 6'd32;
`else
    localparam logic [5:0] CHAR_LAST = 6'd26;
`endif

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [5:0]       char_idx_q, char_idx_d;
    logic [7:0]       snap_a_q, snap_x_q, snap_y_q, snap_sp_q, snap_p_q;
    logic [15:0]      snap_pc_q;
    logic             busy_q, done_q, tx_q, tx_d;
    logic [7:0]       char_byte;
    logic             wrap, accept;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

`ifdef REG_DUMP_FLAGS_DECODE_EN
    function automatic logic [7:0] flag_ascii(input logic set, input logic [7:0] letter);
        return set ? letter : 8'h2D;
    endfunction
`endif

    assign wrap = (baud_cnt_q == CNT_LAST);
    // busy_q lags state_q by one cycle; requiring both low keeps a trigger
    // from being accepted on the first START cycle or on the done cycle.
    assign accept = dbg.trigger && !busy_q && (state_q == IDLE);

    always_comb begin
        char_byte = 8'h20;
        case (char_idx_q)
            6'd0:  char_byte = 8'h41;
            6'd1:  char_byte = hex_ascii(snap_a_q[7:4]);
            6'd2:  char_byte = hex_ascii(snap_a_q[3:0]);
            6'd4:  char_byte = 8'h58;
            6'd5:  char_byte = hex_ascii(snap_x_q[7:4]);
            6'd6:  char_byte = hex_ascii(snap_x_q[3:0]);
            6'd8:  char_byte = 8'h59;
            6'd9:  char_byte = hex_ascii(snap_y_q[7:4]);
            6'd10: char_byte = hex_ascii(snap_y_q[3:0]);
            6'd12: char_byte = 8'h53;
            6'd13: char_byte = hex_ascii(snap_sp_q[7:4]);
            6'd14: char_byte = hex_ascii(snap_sp_q[3:0]);
            6'd16: char_byte = 8'h50;
            6'd17: char_byte = hex_ascii(snap_pc_q[15:12]);
            6'd18: char_byte = hex_ascii(snap_pc_q[11:8]);
            6'd19: char_byte = hex_ascii(snap_pc_q[7:4]);
            6'd20: char_byte = hex_ascii(snap_pc_q[3:0]);
            6'd22: char_byte = 8'h46;
`ifdef REG_DUMP_FLAGS_DECODE_EN
            6'd23: char_byte = flag_ascii(snap_p_q[7], 8'h4E);
            6'd24: char_byte = flag_ascii(snap_p_q[6], 8'h56);
            6'd25: char_byte = flag_ascii(snap_p_q[5], 8'h55);
            6'd26: char_byte = flag_ascii(snap_p_q[4], 8'h42);
            6'd27: char_byte = flag_ascii(snap_p_q[3], 8'h44);
            6'd28: char_byte = flag_ascii(snap_p_q[2], 8'h49);
            6'd29: char_byte = flag_ascii(snap_p_q[1], 8'h5A);
            6'd30: char_byte = flag_ascii(snap_p_q[0], 8'h43);
            6'd31: char_byte = 8'h0D;
            6'd32: char_byte = 8'h0A;
`else
            6'd23: char_byte = hex_ascii(snap_p_q[7:4]);
            6'd24: char_byte = hex_ascii(snap_p_q[3:0]);
            6'd25: char_byte = 8'h0D;
            6'd26: char_byte = 8'h0A;
`endif
            default: char_byte = 8'h20;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    char_idx_d = 6'd0;
                end
            end
            START: begin
                if (wrap) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (wrap) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (wrap) begin
                    baud_cnt_d = '0;
                    if (char_idx_q == CHAR_LAST) begin
                        state_d = IDLE;
                    end else begin
                        char_idx_d = char_idx_q + 6'd1;
                        state_d    = START;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = char_byte[bit_idx_q];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            char_idx_q <= 6'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
            // Outputs trail the FSM by one cycle, so busy/done/uart_tx all
            // move together one edge after the state does.
            busy_q     <= (state_q != IDLE);
            done_q     <= (state_q == IDLE) && busy_q;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_a_q  <= 8'h00;
            snap_x_q  <= 8'h00;
            snap_y_q  <= 8'h00;
            snap_sp_q <= 8'h00;
            snap_p_q  <= 8'h00;
            snap_pc_q <= 16'h0000;
        end else if (accept) begin
            snap_a_q  <= dbg.reg_a;
            snap_x_q  <= dbg.reg_x;
            snap_y_q  <= dbg.reg_y;
            snap_sp_q <= dbg.reg_sp;
            snap_p_q  <= dbg.reg_p;
            snap_pc_q <= dbg.reg_pc;
        end
    end

    assign dbg.busy    = busy_q;
    assign dbg.done    = done_q;
    assign dbg.uart_tx = tx_q;
endmodule

// File: doc/cpu_reg_dump_tx.md
# cpu_reg_dump_tx

Snapshots the CPU debug register bus (A, X, Y, SP, PC, P) on a trigger and transmits it as one fixed-format ASCII hex line over a UART 8N1 transmitter. It sits beside `cpu_registers` on the debug side of the board top and reads what the register test sequencer writes, giving the board a serial readout of CPU state.

## Interface

Parameters:
- `CLK_HZ`, default 27000000: input clock frequency in Hz.
- `BAUD`, default 115200: UART bit rate. `DIV = CLK_HZ / BAUD` uses integer floor, so DIV is 234 at the defaults. DIV must be at least 2.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `trigger`  in  1: dump request. It is sampled at every posedge.
- `reg_a`, `reg_x`, `reg_y`, `reg_sp`, `reg_p`  in  8 each: register values.
- `reg_pc`  in  16: program counter.
- `busy`  out  1: high while a line is being captured or sent.
- `done`  out  1: one-cycle pulse after the last stop bit.
- `uart_tx`  out  1: serial output. It idles high.

## Operation

- FSM has 4 states:
  - IDLE: `uart_tx=1`, `busy=0`.
  - START: bit 0 of the frame, `uart_tx=0`.
  - DATA: 8 bits, LSB first.
  - STOP: `uart_tx=1` for one bit.
- Accept rule: `trigger=1` at an edge where `busy=0` is accepted. At that edge, all six registers are latched into a snapshot, the character index is reset to 0, and the FSM moves to START.
- Triggers while `busy=1` are ignored. They are neither queued nor counted.
- Register inputs are not used after the accept edge. Later changes do not affect the line in flight.
- Line format is 27 characters: `A55 XAA Y33 SFD P1234 F24` followed by CR (0x0D) and LF (0x0A).
  - Each field is a tag letter followed by hex digits, most significant nibble first.
  - Tags: A is reg_a, X is reg_x, Y is reg_y, S is reg_sp, P is reg_pc (4 digits), F is reg_p (2 digits).
  - Fields are separated by a single space (0x20).
- Hex digits are uppercase ASCII. Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46.
- Character source: generated combinationally from the snapshot and the character index (0..26). No ROM is used.
- Character transitions: after the STOP bit of character k, if k is less than the last index, the FSM goes directly to START of character k+1 with no idle gap.
- End of line: after the last character's STOP bit, the FSM returns to IDLE, `busy` goes to 0 and `done` goes to 1 for one cycle.

## Timing

- Reset values: `uart_tx=1`, `busy=0`, `done=0`, FSM in IDLE, counters 0.
- Reset is asynchronous. Asserting reset mid-line aborts immediately, with no partial stop bit, and forces all reset values.
- All outputs are registered.
- After an accept at edge E:
  - `busy=1` and `uart_tx=0` (first start bit) from edge E+1.
  - Every bit lasts exactly DIV cycles. A bit counter runs 0..DIV-1 and the bit advances on wrap.
- Line duration: 27 chars × 10 bits × DIV cycles, which is 63180 cycles at the defaults. `busy` and `done` change at edge E + 1 + 270·DIV.
- Back-to-back dumps: a trigger held high at the edge after `done` is accepted. The minimum idle time between lines is 1 cycle.
- `done` and `busy=1` are never high together.

## Configuration

- Macro: `REG_DUMP_FLAGS_DECODE_EN`.
- When defined, the F field is the tag F followed by 8 flag letters, bit 7 down to bit 0, in the order N V U B D I Z C. A set bit prints as its uppercase letter; a clear bit prints as `-`. The line becomes 33 characters, and the duration becomes 330·DIV cycles.
- When not defined, the F field is 2 hex digits and the line is 27 characters.

## Test plan

All scenarios use CLK_HZ=1000000 and BAUD=100000, so DIV=10.

- **Reset:** hold `rst_n` low, then release it. Required: `uart_tx=1`, `busy=0`, `done=0`, and no activity for 1000 cycles.
- **Basic dump:** A=55, X=AA, Y=33, SP=FD, PC=1234, P=24, then pulse `trigger`. Required:
  - The UART decodes to bytes 41 35 35 20 58 41 41 20 59 33 33 20 53 46 44 20 50 31 32 33 34 20 46 32 34 0D 0A.
  - The first start bit begins 1 cycle after the accept edge.
  - `done` pulses 2700 cycles after that.
- **Snapshot and ignore:** trigger, then change every register to 00 and pulse `trigger` again at cycle 500. Required: the original line is sent unchanged, only one `done` pulse occurs, and `busy` stays high throughout.
- **Reset mid-line:** assert `rst_n=0` during character 5. Required: `uart_tx=1` and `busy=0` immediately. A new trigger after release sends a complete line starting with 0x41.
- **Back-to-back:** hold `trigger` high. Required: the second start bit of the next line follows `done` by exactly 2 cycles.
- **Flags decode:** with `REG_DUMP_FLAGS_DECODE_EN` defined, P=A5. Required: the F field reads `FN-U--I-C`, the line is 33 bytes, and `done` pulses after 3300 cycles.
